// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential 14-bit binary to 4-digit packed BCD converter.
//
// Uses the double-dabble algorithm, one bit per clock: a conversion accepted
// at edge E0 finishes at edge E14 and pulses done in the following cycle.
// A 5-digit scratch register keeps inputs up to 16383 exact; the fifth
// (ten-thousands) digit only drives overflow.
//
// Optional build macro:
//   BIN2BCD_SATURATE_EN  when defined, results above 9999 show 16'h9999;
//                        otherwise they show the low four digits.
//
// Ports:
//   clock     in   1   sole clock, rising edge
//   reset     in   1   asynchronous active-high reset
//   bin       in  14   unsigned value, sampled when a start is accepted
//   start     in   1   conversion request (pulse or level)
//   dp_pos    in   2   decimal-point digit index, 0 = rightmost
//   dp_en     in   1   decimal-point enable
//   value     out 16   packed BCD result, [15:12] most significant
//   dots      out  4   one-hot decimal-point mask aligned to value digits
//   busy      out  1   high while a conversion is running
//   done      out  1   one-cycle pulse when value/dots/overflow update
//   overflow  out  1   last converted bin exceeded 9999

module bin2bcd_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic [13:0] bin,
  input  logic        start,
  input  logic [1:0]  dp_pos,
  input  logic        dp_en,
  output logic [15:0] value,
  output logic [3:0]  dots,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_reg;
  logic [13:0] bin_reg;
  logic [19:0] scratch_reg;
  logic [3:0]  cnt_reg;
  logic [1:0]  dp_pos_reg;
  logic        dp_en_reg;

  logic [19:0] adj_next;
  logic [19:0] scratch_next;
  logic [15:0] value_next;
  logic [3:0]  dots_next;
  logic        overflow_next;

  // Add-3 correction on every BCD nibble that would reach 10+ after the shift.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_adj
      assign adj_next[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                   ? scratch_reg[gi*4 +: 4] + 4'd3
                                   : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  // Shift the corrected digits left, pulling in the next binary MSB.
  assign scratch_next = {adj_next[18:0], bin_reg[13]};

  // Final-result decode; only meaningful on the last iteration.
  assign overflow_next = |scratch_next[19:16];
  assign dots_next     = dp_en_reg ? (4'b0001 << dp_pos_reg) : 4'b0000;

`ifdef BIN2BCD_SATURATE_EN
  assign value_next = overflow_next ? 16'h9999 : scratch_next[15:0];
`else
  assign value_next = scratch_next[15:0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      dp_pos_reg  <= '0;
      dp_en_reg   <= 1'b0;
      value       <= 16'h0000;
      dots        <= 4'b0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg     <= bin;
            dp_pos_reg  <= dp_pos;
            dp_en_reg   <= dp_en;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            busy        <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_reg <= scratch_next;
          bin_reg     <= {bin_reg[12:0], 1'b0};
          cnt_reg     <= cnt_reg + 4'd1;
          // cnt_reg == 13 marks the 14th iteration (edge E14).
          if (cnt_reg == 4'd13) begin
            value     <= value_next;
            dots      <= dots_next;
            overflow  <= overflow_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic [13:0] bin;
  logic        start;
  logic [1:0]  dp_pos;
  logic        dp_en;
  logic [15:0] value;
  logic [3:0]  dots;
  logic        busy;
  logic        done;
  logic        overflow;

  int errors = 0;
  int checks = 0;

`ifdef BIN2BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [13:0] b;
    logic [1:0]  p;
    logic        e;
    logic [15:0] xv;
    logic [3:0]  xd;
    logic        xo;
  } vec_t;

  vec_t vecs[10];

  bin2bcd_seq dut (
    .clock    (clk),
    .reset    (reset),
    .bin      (bin),
    .start    (start),
    .dp_pos   (dp_pos),
    .dp_en    (dp_en),
    .value    (value),
    .dots     (dots),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Runs one conversion starting at a negedge; returns at a negedge with done low.
  task automatic run_conv(input string name, input logic [13:0] b, input logic [1:0] p,
                          input logic e, input logic [15:0] xv, input logic [3:0] xd,
                          input logic xo);
    logic [15:0] prev_v;
    int edges;
    int busy_cycles;
    bit held;
    prev_v = value;
    held = 1'b1;
    edges = 0;
    busy_cycles = 0;
    bin = b; dp_pos = p; dp_en = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble the inputs so a missing capture shows up in the result.
    bin = ~b; dp_pos = ~p; dp_en = ~e;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cycles++;
      if (value !== prev_v) held = 1'b0;
      @(negedge clk);
      edges++;
    end
    chk({name, "_latency"}, edges, 14);
    chk({name, "_busy_cycles"}, busy_cycles, 14);
    chk({name, "_hold"}, {31'd0, held}, 1);
    chk({name, "_value"}, {16'd0, value}, {16'd0, xv});
    chk({name, "_dots"}, {28'd0, dots}, {28'd0, xd});
    chk({name, "_overflow"}, {31'd0, overflow}, {31'd0, xo});
    @(negedge clk);
    chk({name, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  initial begin
    int n;
    int ndone;
    int first_k;
    int second_k;
    logic [15:0] seen_v;
    logic [3:0]  seen_d;

    vecs[0] = '{14'd1234,  2'd0, 1'b0, 16'h1234, 4'b0000, 1'b0};
    vecs[1] = '{14'd0,     2'd1, 1'b0, 16'h0000, 4'b0000, 1'b0};
    vecs[2] = '{14'd9999,  2'd3, 1'b1, 16'h9999, 4'b1000, 1'b0};
    vecs[3] = '{14'd12345, 2'd0, 1'b0, SAT ? 16'h9999 : 16'h2345, 4'b0000, 1'b1};
    vecs[4] = '{14'd16383, 2'd1, 1'b1, SAT ? 16'h9999 : 16'h6383, 4'b0010, 1'b1};
    vecs[5] = '{14'd10000, 2'd0, 1'b1, SAT ? 16'h9999 : 16'h0000, 4'b0001, 1'b1};
    vecs[6] = '{14'd42,    2'd2, 1'b1, 16'h0042, 4'b0100, 1'b0};
    vecs[7] = '{14'd7,     2'd3, 1'b0, 16'h0007, 4'b0000, 1'b0};
    vecs[8] = '{14'd9998,  2'd0, 1'b1, 16'h9998, 4'b0001, 1'b0};
    vecs[9] = '{14'd5005,  2'd2, 1'b0, 16'h5005, 4'b0000, 1'b0};

    reset = 1'b0; start = 1'b0; bin = '0; dp_pos = '0; dp_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_value", {16'd0, value}, 0);
    chk("rst_dots", {28'd0, dots}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_conv($sformatf("vec%0d", i), vecs[i].b, vecs[i].p, vecs[i].e,
               vecs[i].xv, vecs[i].xd, vecs[i].xo);
    end

    // Back-to-back: 9999 then 0, second start in the done cycle.
    bin = 14'd9999; dp_pos = 2'd0; dp_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("b2b_first_latency", n + 1, 15);
    chk("b2b_first_value", {16'd0, value}, 32'h9999);
    chk("b2b_first_overflow", {31'd0, overflow}, 0);
    bin = 14'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("b2b_spacing", n, 15);
    chk("b2b_second_value", {16'd0, value}, 32'h0000);
    chk("b2b_second_overflow", {31'd0, overflow}, 0);
    @(negedge clk);

    // Start during busy is ignored; inputs changed mid-conversion are not used.
    bin = 14'd42; dp_pos = 2'd2; dp_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    bin = 14'd999; dp_pos = 2'd0; dp_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; seen_v = '0; seen_d = '0;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) begin ndone++; seen_v = value; seen_d = dots; end
      @(negedge clk);
    end
    chk("ignore_done_count", ndone, 1);
    chk("ignore_value", {16'd0, seen_v}, 32'h0042);
    chk("ignore_dots", {28'd0, seen_d}, 32'b0100);

    // Held start level restarts a conversion each time the block returns to IDLE.
    bin = 14'd77; dp_pos = 2'd0; dp_en = 1'b0; start = 1'b1;
    ndone = 0; first_k = 0; second_k = 0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) first_k = k;
        if (ndone == 2) second_k = k;
      end
    end
    start = 1'b0;
    chk("held_done_count", ndone, 2);
    chk("held_first_latency", first_k, 15);
    chk("held_spacing", second_k - first_k, 15);
    chk("held_value", {16'd0, value}, 32'h0077);
    repeat (20) @(negedge clk);

    // Asynchronous reset mid-conversion.
    run_conv("pre_rst", 14'd5678, 2'd1, 1'b1, 16'h5678, 4'b0010, 1'b0);
    bin = 14'd1111; dp_pos = 2'd0; dp_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_value", {16'd0, value}, 0);
    chk("arst_dots", {28'd0, dots}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_overflow", {31'd0, overflow}, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("arst_no_done", ndone, 0);
    chk("arst_value_stays", {16'd0, value}, 0);

    // First edge with start after reset is accepted.
    run_conv("post_rst", 14'd1234, 2'd0, 1'b0, 16'h1234, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 14-bit binary in and 4 BCD digits out.
REQ-002 clock  input  1  Sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-high reset.
REQ-004 bin  input  14  Unsigned binary value to convert; sampled only when a start is accepted.
REQ-005 start  input  1  Conversion request; a one-cycle pulse or a level.
REQ-006 dp_pos  input  2  Decimal-point digit index (0 = rightmost); sampled with bin.
REQ-007 dp_en  input  1  Decimal-point enable; sampled with bin.
REQ-008 value  output  16  Four packed BCD digits, [15:12] most significant; feeds the display driver's value input.
REQ-009 dots  output  4  One-hot decimal-point mask aligned to value digits; feeds the display driver's dots input.
REQ-010 busy  output  1  High while a conversion is in progress.
REQ-011 done  output  1  Single-cycle pulse when value, dots and overflow update.
REQ-012 overflow  output  1  High when the last converted bin exceeded 9999.

Function
REQ-013 The FSM SHALL have two states: IDLE and SHIFT.
REQ-014 In IDLE, start=1 at a rising edge (E0) SHALL capture bin, dp_pos and dp_en, clear the BCD scratch register, load the iteration counter with 0, and enter SHIFT.
REQ-015 In SHIFT, each edge E1..E14 SHALL perform one double-dabble iteration: add 3 to every scratch BCD nibble >= 5, then shift left by one, taking the MSB of the remaining binary.
REQ-016 The scratch register SHALL hold 5 BCD digits (20 bits) so that inputs up to 16383 convert exactly.
REQ-017 At E14 the block SHALL write value, dots and overflow from the final result, return to IDLE, and drive done=1 for exactly the following cycle.
REQ-018 Latency SHALL be fixed: done is high in the cycle after E14, i.e. 14 edges after the accepting edge E0, independent of data.
REQ-019 busy SHALL be 1 from after E0 through E14 (14 cycles), and 0 otherwise.
REQ-020 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 start=1 in the cycle where done=1 SHALL be accepted (state is IDLE), giving back-to-back conversions every 15 cycles.
REQ-022 value, dots and overflow SHALL hold their previous result throughout a conversion; intermediate scratch data SHALL never appear on the outputs.
REQ-023 dots SHALL be 4'b0001 shifted left by the captured dp_pos when the captured dp_en=1, and 4'b0000 otherwise.
REQ-024 overflow SHALL be 1 if and only if the fifth (ten-thousands) BCD digit of the result is nonzero.
REQ-025 A held start level SHALL restart a conversion each time the block returns to IDLE.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, value=16'h0000, dots=4'b0000, busy=0, done=0, overflow=0, and clear the counter and scratch register.
REQ-027 reset asserted mid-conversion SHALL abort the conversion; no done pulse SHALL follow.
REQ-028 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-029 With macro BIN2BCD_SATURATE_EN defined, a result above 9999 SHALL drive value=16'h9999 with overflow=1.
REQ-030 Without BIN2BCD_SATURATE_EN, a result above 9999 SHALL drive value to the low four BCD digits (bin mod 10000) with overflow=1.
REQ-031 Results of 9999 or less SHALL be identical in both builds.

Verification
REQ-032 bin=1234, dp_en=0, start pulse -> done exactly 14 edges later; value=16'h1234, dots=4'b0000, overflow=0; busy high for 14 cycles.
REQ-033 bin=9999, then bin=0 back-to-back (second start in the done cycle) -> 16'h9999 then 16'h0000, both with overflow=0, 15 cycles apart.
REQ-034 bin=12345 -> overflow=1; value=16'h9999 with BIN2BCD_SATURATE_EN, 16'h2345 without; run both builds.
REQ-035 bin=42, dp_pos=2, dp_en=1; change bin and dp_pos during busy and pulse start mid-conversion -> single done, value=16'h0042, dots=4'b0100.
REQ-036 Complete bin=5678, then start bin=1111 and assert reset asynchronously at cycle 7 of the conversion -> all outputs 0 before the next edge, no done pulse, value stays 16'h0000.
